// File: rtl/compare_alarm_fsm.sv
// Debounced, hysteretic over-threshold alarm driven by 4-bit comparator flags.
// Also counts alarm events (saturating) and flags illegal flag combinations.
module compare_alarm_fsm #(
  parameter int unsigned SET_COUNT = 3,
  parameter int unsigned CLR_COUNT = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             A_eq_B,
  input  logic             A_gt_B,
  input  logic             A_lt_B,
  output logic             alarm,
  output logic             alarm_rise,
  output logic             alarm_fall,
  output logic [3:0]       run_cnt,
  output logic [CNT_W-1:0] event_cnt,
  output logic             flag_err
);

  typedef enum logic [1:0] {StIdle, StArming, StAlarm, StClearing} state_e;

  localparam logic [3:0]       SetCnt = 4'(SET_COUNT);
  localparam logic [3:0]       ClrCnt = 4'(CLR_COUNT);
  localparam logic [CNT_W-1:0] EvMax  = '1;

  state_e           state_q, state_d;
  logic [3:0]       run_q, run_d;
  logic [CNT_W-1:0] ev_q, ev_d;
  logic             alarm_q, alarm_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             err_q, err_d;

  logic       is_gt, is_le;
  logic [3:0] run_inc;

  assign is_gt   = A_gt_B & ~A_eq_B & ~A_lt_B;
  assign is_le   = (A_eq_B ^ A_lt_B) & ~A_gt_B;
  // Counts never exceed 14 before wrapping back to 0, so 4 bits cannot overflow.
  assign run_inc = run_q + 4'd1;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    ev_d    = ev_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    err_d   = 1'b0;

    if (in_valid) begin
      if (!is_gt && !is_le) begin
        err_d = 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (is_gt) begin
              run_d   = 4'd1;
              state_d = (SET_COUNT == 1) ? StAlarm : StArming;
            end else begin
              run_d = 4'd0;
            end
          end
          StArming: begin
            if (is_gt) begin
              if (run_inc == SetCnt) begin
                state_d = StAlarm;
                run_d   = 4'd0;
              end else begin
                run_d = run_inc;
              end
            end else begin
              state_d = StIdle;
              run_d   = 4'd0;
            end
          end
          StAlarm: begin
            if (is_gt) begin
              run_d = 4'd0;
            end else begin
              run_d   = 4'd1;
              state_d = (CLR_COUNT == 1) ? StIdle : StClearing;
            end
          end
          StClearing: begin
            if (is_le) begin
              if (run_inc == ClrCnt) begin
                state_d = StIdle;
                run_d   = 4'd0;
              end else begin
                run_d = run_inc;
              end
            end else begin
              // Bounce back: still the same alarm episode, not a new event.
              state_d = StAlarm;
              run_d   = 4'd0;
            end
          end
          default: begin
            state_d = StIdle;
            run_d   = 4'd0;
          end
        endcase
      end
    end

    alarm_d = (state_d == StAlarm) || (state_d == StClearing);
    if (alarm_d && !alarm_q) begin
      rise_d = 1'b1;
      if (ev_q != EvMax) begin
        ev_d = ev_q + 1'b1;
      end
    end
    if (!alarm_d && alarm_q) begin
      fall_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      run_q   <= 4'd0;
      ev_q    <= '0;
      alarm_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      ev_q    <= ev_d;
      alarm_q <= alarm_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      err_q   <= err_d;
    end
  end

  assign alarm      = alarm_q;
  assign alarm_rise = rise_q;
  assign alarm_fall = fall_q;
  assign run_cnt    = run_q;
  assign event_cnt  = ev_q;
  assign flag_err   = err_q;

endmodule

// File: tb/tb_compare_alarm_fsm.sv
// Bench for compare_alarm_fsm: directed vector table, hand sequences and
// random stimulus checked against a streak-counting reference model.
module tb_compare_alarm_fsm;

  localparam int SetN = 3;
  localparam int ClrN = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, eq = 1'b0, gt = 1'b0, lt = 1'b0;

  logic       alarm, rise, fall, err;
  logic [3:0] run;
  logic [7:0] ev;
  logic       alarm2, rise2, fall2, err2;
  logic [3:0] run2;
  logic [1:0] ev2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  compare_alarm_fsm #(.SET_COUNT(SetN), .CLR_COUNT(ClrN), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .A_eq_B(eq), .A_gt_B(gt), .A_lt_B(lt),
    .alarm(alarm), .alarm_rise(rise), .alarm_fall(fall),
    .run_cnt(run), .event_cnt(ev), .flag_err(err)
  );

  compare_alarm_fsm #(.SET_COUNT(SetN), .CLR_COUNT(ClrN), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .A_eq_B(eq), .A_gt_B(gt), .A_lt_B(lt),
    .alarm(alarm2), .alarm_rise(rise2), .alarm_fall(fall2),
    .run_cnt(run2), .event_cnt(ev2), .flag_err(err2)
  );

  // Reference model: streak lengths and an alarm level.
  bit m_alarm, m_rise, m_fall, m_err;
  int m_gt_run, m_le_run, m_events, m_run;

  task automatic model_reset();
    m_alarm = 0; m_rise = 0; m_fall = 0; m_err = 0;
    m_gt_run = 0; m_le_run = 0; m_events = 0; m_run = 0;
  endtask

  task automatic model_step(input bit v, input bit e, input bit g, input bit l);
    int nflags;
    m_rise = 0; m_fall = 0; m_err = 0;
    if (!v) return;
    nflags = int'(e) + int'(g) + int'(l);
    if (nflags != 1) begin
      m_err = 1;
    end else if (g) begin
      m_le_run = 0;
      if (m_alarm) begin
        m_run = 0;
      end else begin
        m_gt_run++;
        if (m_gt_run >= SetN) begin
          m_alarm = 1; m_rise = 1; m_events++;
          m_run = (SetN == 1) ? 1 : 0;
          m_gt_run = 0;
        end else begin
          m_run = m_gt_run;
        end
      end
    end else begin
      m_gt_run = 0;
      if (!m_alarm) begin
        m_run = 0;
      end else begin
        m_le_run++;
        if (m_le_run >= ClrN) begin
          m_alarm = 0; m_fall = 1;
          m_run = (ClrN == 1) ? 1 : 0;
          m_le_run = 0;
        end else begin
          m_run = m_le_run;
        end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    int sat2;
    sat2 = (m_events > 3) ? 3 : m_events;
    chk("alarm", int'(alarm), int'(m_alarm));
    chk("alarm_rise", int'(rise), int'(m_rise));
    chk("alarm_fall", int'(fall), int'(m_fall));
    chk("run_cnt", int'(run), m_run);
    chk("event_cnt", int'(ev), (m_events > 255) ? 255 : m_events);
    chk("flag_err", int'(err), int'(m_err));
    chk("event_cnt_w2", int'(ev2), sat2);
    chk("alarm_w2", int'(alarm2), int'(m_alarm));
  endtask

  task automatic apply(input bit v, input bit e, input bit g, input bit l);
    in_valid = v; eq = e; gt = g; lt = l;
    @(posedge clk);
    #1;
    model_step(v, e, g, l);
    chk_model();
  endtask

  typedef struct {
    bit v, e, g, l;
    bit x_alarm, x_rise, x_fall, x_err;
    int x_run, x_ev;
  } vec_t;

  vec_t tbl[$];

  initial begin
    //            v  e  g  l   al ri fa er run ev
    tbl.push_back('{1, 0, 1, 0,  0, 0, 0, 0, 1, 0});  // set path
    tbl.push_back('{1, 0, 1, 0,  0, 0, 0, 0, 2, 0});
    tbl.push_back('{1, 0, 1, 0,  1, 1, 0, 0, 0, 1});
    tbl.push_back('{1, 0, 0, 1,  1, 0, 0, 0, 1, 1});  // clear with bounce
    tbl.push_back('{1, 0, 1, 0,  1, 0, 0, 0, 0, 1});
    tbl.push_back('{1, 0, 0, 1,  1, 0, 0, 0, 1, 1});
    tbl.push_back('{1, 1, 0, 0,  0, 0, 1, 0, 0, 1});
    tbl.push_back('{1, 0, 1, 0,  0, 0, 0, 0, 1, 1});  // broken arming
    tbl.push_back('{1, 0, 1, 0,  0, 0, 0, 0, 2, 1});
    tbl.push_back('{1, 0, 0, 1,  0, 0, 0, 0, 0, 1});
    tbl.push_back('{1, 0, 1, 0,  0, 0, 0, 0, 1, 1});  // gaps and illegal flags
    tbl.push_back('{0, 0, 1, 0,  0, 0, 0, 0, 1, 1});
    tbl.push_back('{0, 1, 0, 1,  0, 0, 0, 0, 1, 1});
    tbl.push_back('{1, 0, 1, 0,  0, 0, 0, 0, 2, 1});
    tbl.push_back('{1, 1, 1, 0,  0, 0, 0, 1, 2, 1});
    tbl.push_back('{1, 0, 1, 0,  1, 1, 0, 0, 0, 2});
    tbl.push_back('{1, 0, 0, 0,  1, 0, 0, 1, 0, 2});
    tbl.push_back('{1, 1, 1, 1,  1, 0, 0, 1, 0, 2});

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_alarm", int'(alarm), 0);
    chk("reset_run_cnt", int'(run), 0);
    chk("reset_event_cnt", int'(ev), 0);
    chk("reset_pulses", int'({rise, fall, err}), 0);
    rst_n = 1'b1;
    apply(0, 0, 0, 0);

    foreach (tbl[i]) begin
      apply(tbl[i].v, tbl[i].e, tbl[i].g, tbl[i].l);
      chk($sformatf("tbl%0d_alarm", i), int'(alarm), int'(tbl[i].x_alarm));
      chk($sformatf("tbl%0d_rise", i), int'(rise), int'(tbl[i].x_rise));
      chk($sformatf("tbl%0d_fall", i), int'(fall), int'(tbl[i].x_fall));
      chk($sformatf("tbl%0d_err", i), int'(err), int'(tbl[i].x_err));
      chk($sformatf("tbl%0d_run", i), int'(run), tbl[i].x_run);
      chk($sformatf("tbl%0d_ev", i), int'(ev), tbl[i].x_ev);
    end

    // Drop the alarm, then five full set/clear cycles to saturate the 2-bit counter.
    apply(1, 0, 0, 1);
    apply(1, 0, 0, 1);
    chk("pre_sat_alarm", int'(alarm), 0);
    for (int c = 0; c < 5; c++) begin
      repeat (SetN) apply(1, 0, 1, 0);
      repeat (ClrN) apply(1, 1, 0, 0);
    end
    chk("sat_event_cnt_w2", int'(ev2), 3);
    chk("nosat_event_cnt_w8", int'(ev), 7);

    for (int k = 0; k < 1500; k++) begin
      int r;
      bit v, e, g, l;
      v = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      e = 0; g = 0; l = 0;
      if (r < 5) g = 1;
      else if (r < 7) e = 1;
      else if (r < 9) l = 1;
      else {e, g, l} = 3'($urandom_range(0, 7));
      apply(v, e, g, l);
    end

    // Async reset between edges while arming.
    apply(1, 0, 0, 1);
    apply(1, 0, 0, 1);
    apply(1, 0, 0, 1);
    apply(1, 0, 1, 0);
    chk("arming_run_cnt", int'(run), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_alarm", int'(alarm), 0);
    chk("async_run_cnt", int'(run), 0);
    chk("async_event_cnt", int'(ev), 0);
    chk("async_event_cnt_w2", int'(ev2), 0);
    chk("async_pulses", int'({rise, fall, err}), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    apply(1, 0, 1, 0);
    chk("post_reset_run", int'(run), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
